// File: rtl/rx_if.sv
// rtl/rx_if.sv - host-side signal bundle for the rx serial receiver
//   en      : baud oversample tick, one clk wide, OSR ticks per bit
//   RxD     : serial line, idle high, asynchronous to clk
//   clr_rda : host has consumed data; clears rda (and ferr)
//   data    : last correctly framed received byte
//   rda     : received data available flag
//   ferr    : framing error flag, only when SPART_RX_FERR_EN is defined
// master modport = host/bench side, slave modport = receiver side.
interface rx_if;
  logic       en;
  logic       RxD;
  logic       clr_rda;
  logic [7:0] data;
  logic       rda;
`ifdef SPART_RX_FERR_EN
  logic       ferr;

  modport master (output en, RxD, clr_rda, input data, rda, ferr);
  modport slave  (input en, RxD, clr_rda, output data, rda, ferr);
`else
  modport master (output en, RxD, clr_rda, input data, rda);
  modport slave  (input en, RxD, clr_rda, output data, rda);
`endif
endinterface

// File: rtl/rx.sv
// rtl/rx.sv - 8N1 serial receiver with oversampled start/bit/stop sampling
//   Parameter OSR : en ticks per bit period (power of two, 4..16)
//   clk           : single clock, rising edge
//   rst           : asynchronous active-high reset
//   bus (rx_if.slave) : en, RxD, clr_rda in; data, rda (and ferr) out
//   Optional macro SPART_RX_FERR_EN adds the ferr framing-error flag.
module rx #(
  parameter int OSR = 16
) (
  input  logic clk,
  input  logic rst,
  rx_if.slave  bus
);
  localparam int            CW      = $clog2(OSR);
  localparam logic [CW-1:0] HALF_M1 = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OSR - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state;
  logic [1:0]    r_sync;
  logic          w_rxd_s;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_shift, w_shift;
  logic [7:0]    r_data, w_data;
  logic          r_rda, w_rda;
  logic          r_armed, w_armed;
  logic          w_cnt_zero;
`ifdef SPART_RX_FERR_EN
  logic          r_ferr, w_ferr;
`endif

  assign w_rxd_s    = r_sync[1];
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_rda   <= 1'b0;
      r_armed <= 1'b1;
`ifdef SPART_RX_FERR_EN
      r_ferr  <= 1'b0;
`endif
    end else begin
      r_sync  <= {r_sync[0], bus.RxD};
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_rda   <= w_rda;
      r_armed <= w_armed;
`ifdef SPART_RX_FERR_EN
      r_ferr  <= w_ferr;
`endif
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_data  = r_data;
    w_armed = r_armed;
    // Host clear applies first so that a same-edge good stop overrides it.
    w_rda   = r_rda & ~bus.clr_rda;
`ifdef SPART_RX_FERR_EN
    w_ferr  = r_ferr & ~bus.clr_rda;
`endif
    if (bus.en) begin
      case (r_state)
        IDLE: begin
          if (w_rxd_s) begin
            w_armed = 1'b1;
          end else if (r_armed) begin
            // Half a bit to land the start sample mid-bit.
            w_state = START;
            w_cnt   = HALF_M1;
          end
        end
        START: begin
          if (w_cnt_zero) begin
            if (!w_rxd_s) begin
              w_state = DATA;
              w_cnt   = FULL_M1;
              w_bit   = 3'd0;
            end else begin
              w_state = IDLE;
            end
          end else begin
            w_cnt = r_cnt - CNT_ONE;
          end
        end
        DATA: begin
          if (w_cnt_zero) begin
            w_shift = {w_rxd_s, r_shift[7:1]};
            w_cnt   = FULL_M1;
            w_bit   = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state = STOP;
          end else begin
            w_cnt = r_cnt - CNT_ONE;
          end
        end
        STOP: begin
          if (w_cnt_zero) begin
            w_state = IDLE;
            if (w_rxd_s) begin
              w_data = r_shift;
              w_rda  = 1'b1;
`ifdef SPART_RX_FERR_EN
              w_ferr = 1'b0;
`endif
            end else begin
              // Bad stop: wait for the line to return high before the
              // next start so a held-low break cannot spawn frames.
              w_armed = 1'b0;
`ifdef SPART_RX_FERR_EN
              w_ferr  = 1'b1;
`endif
            end
          end else begin
            w_cnt = r_cnt - CNT_ONE;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  assign bus.data = r_data;
  assign bus.rda  = r_rda;
`ifdef SPART_RX_FERR_EN
  assign bus.ferr = r_ferr;
`endif

endmodule

// File: tb/tb_rx.sv
// tb/tb_rx.sv - self-checking bench for rx (frame-level model + directed frames)
module tb_rx;
  localparam int OSR    = 16;
  localparam int ENDIV  = 4;
  localparam int BITCLK = OSR * ENDIV;
  localparam int STOP_TICK = OSR / 2 + 9 * OSR;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rx_if bus();

  rx #(.OSR(OSR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // en: one clk wide every ENDIV clocks
  initial begin
    int c;
    c = 0;
    bus.en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      bus.en = (c % ENDIV == 0);
    end
  end

  // Frame-level model: counts en ticks since the start was seen and samples
  // the synchronized line at the mid-bit tick offsets of the frame.
  logic       m_s1, m_s2;
  bit         m_busy, m_armed;
  int         m_tick;
  logic [7:0] m_bits, m_data;
  logic       m_rda, m_ferr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_busy = 0; m_armed = 1; m_tick = 0;
      m_bits = 8'h00; m_data = 8'h00; m_rda = 1'b0; m_ferr = 1'b0;
    end else begin
      logic s;
      int   k;
      s    = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.RxD;
      if (bus.clr_rda) begin
        m_rda  = 1'b0;
        m_ferr = 1'b0;
      end
      if (bus.en) begin
        if (!m_busy) begin
          if (s) m_armed = 1;
          else if (m_armed) begin
            m_busy = 1;
            m_tick = 0;
          end
        end else begin
          m_tick++;
          if (m_tick == OSR / 2) begin
            if (s) m_busy = 0;
          end else if (m_tick > OSR / 2 && (m_tick - OSR / 2) % OSR == 0) begin
            k = (m_tick - OSR / 2) / OSR;
            if (k <= 8) m_bits[k-1] = s;
            else begin
              m_busy = 0;
              if (s) begin
                m_data = m_bits;
                m_rda  = 1'b1;
                m_ferr = 1'b0;
              end else begin
                m_armed = 0;
                m_ferr  = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Single compare process: model vs DUT every cycle, plus literal checks
  // requested by the stimulus process.
  int          total = 0;
  int          bad = 0;
  int          lit_seq = 0;
  int          lit_done = 0;
  string       lit_name;
  logic [31:0] lit_act, lit_exp;

  always @(negedge clk) begin
    total++;
    if (bus.data !== m_data) begin
      bad++;
      $display("FAIL model_data act=%0h exp=%0h t=%0t", bus.data, m_data, $time);
    end
    total++;
    if (bus.rda !== m_rda) begin
      bad++;
      $display("FAIL model_rda act=%0b exp=%0b t=%0t", bus.rda, m_rda, $time);
    end
`ifdef SPART_RX_FERR_EN
    total++;
    if (bus.ferr !== m_ferr) begin
      bad++;
      $display("FAIL model_ferr act=%0b exp=%0b t=%0t", bus.ferr, m_ferr, $time);
    end
`endif
    if (lit_seq != lit_done) begin
      lit_done = lit_seq;
      total++;
      if (lit_act !== lit_exp) begin
        bad++;
        $display("FAIL %s act=%0h exp=%0h t=%0t", lit_name, lit_act, lit_exp, $time);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_name = name;
    lit_act  = act;
    lit_exp  = exp;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.RxD = v;
    tick(BITCLK);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic clear_rda();
    bus.clr_rda = 1'b1;
    tick(1);
    bus.clr_rda = 1'b0;
  endtask

  initial begin
    bit found;
    logic [7:0] b55;
    bus.RxD = 1'b1;
    bus.clr_rda = 1'b0;
    b55 = 8'h55;

    tick(3);
    check("rst_data", {24'h0, bus.data}, 32'h00);
    check("rst_rda", {31'h0, bus.rda}, 32'h0);
`ifdef SPART_RX_FERR_EN
    check("rst_ferr", {31'h0, bus.ferr}, 32'h0);
`endif
    rst = 1'b0;
    tick(20);

    // Start glitch of 4 en ticks only
    bus.RxD = 1'b0;
    tick(4 * ENDIV);
    bus.RxD = 1'b1;
    tick(2 * BITCLK);
    check("glitch_rda", {31'h0, bus.rda}, 32'h0);
    check("glitch_data", {24'h0, bus.data}, 32'h00);

    // Bad stop bit, then a good frame
    send(8'h3C, 1'b0);
    bus.RxD = 1'b1;
    tick(BITCLK);
    check("badstop_rda", {31'h0, bus.rda}, 32'h0);
    check("badstop_data", {24'h0, bus.data}, 32'h00);
`ifdef SPART_RX_FERR_EN
    check("badstop_ferr", {31'h0, bus.ferr}, 32'h1);
`endif
    send(8'h81, 1'b1);
    tick(BITCLK);
    check("f81_data", {24'h0, bus.data}, 32'h81);
    check("f81_rda", {31'h0, bus.rda}, 32'h1);
`ifdef SPART_RX_FERR_EN
    check("f81_ferr", {31'h0, bus.ferr}, 32'h0);
`endif
    clear_rda();
    check("f81_cleared", {31'h0, bus.rda}, 32'h0);

    // 0xA5: rda holds until clr_rda, drops one edge later
    send(8'hA5, 1'b1);
    tick(BITCLK);
    check("a5_data", {24'h0, bus.data}, 32'hA5);
    check("a5_rda", {31'h0, bus.rda}, 32'h1);
    tick(200);
    check("a5_rda_held", {31'h0, bus.rda}, 32'h1);
    bus.clr_rda = 1'b1;
    check("a5_rda_before_edge", {31'h0, bus.rda}, 32'h1);
    tick(1);
    bus.clr_rda = 1'b0;
    check("a5_rda_after_clr", {31'h0, bus.rda}, 32'h0);

    // 0x00 then 0xFF back-to-back, clr_rda on the 0xFF stop-sample edge
    send(8'h00, 1'b1);
    check("f00_data", {24'h0, bus.data}, 32'h00);
    check("f00_rda", {31'h0, bus.rda}, 32'h1);
    found = 0;
    fork
      send(8'hFF, 1'b1);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(posedge clk);
          #2;
          if (m_busy && m_tick == STOP_TICK - 1 && bus.en) begin
            bus.clr_rda = 1'b1;
            found = 1;
            break;
          end
        end
        @(posedge clk);
        #2;
        bus.clr_rda = 1'b0;
      end
    join
    check("ff_stop_edge_found", {31'h0, found}, 32'h1);
    check("ff_data", {24'h0, bus.data}, 32'hFF);
    check("ff_rda_set_wins", {31'h0, bus.rda}, 32'h1);

    // Reset during data bit 4 of 0x55
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b55[i]);
    bus.RxD = b55[4];
    tick(BITCLK / 2);
    rst = 1'b1;
    bus.RxD = 1'b1;
    #1;
    check("midrst_data", {24'h0, bus.data}, 32'h00);
    check("midrst_rda", {31'h0, bus.rda}, 32'h0);
    tick(8);
    rst = 1'b0;
    tick(BITCLK);
    send(8'h96, 1'b1);
    tick(BITCLK);
    check("f96_data", {24'h0, bus.data}, 32'h96);
    check("f96_rda", {31'h0, bus.rda}, 32'h1);

    // Bad stop followed by a 3-frame break, then recovery
    clear_rda();
    send(8'h5A, 1'b0);
    tick(3 * 10 * BITCLK);
    check("break_rda", {31'h0, bus.rda}, 32'h0);
    check("break_data", {24'h0, bus.data}, 32'h96);
`ifdef SPART_RX_FERR_EN
    check("break_ferr", {31'h0, bus.ferr}, 32'h1);
`endif
    bus.RxD = 1'b1;
    tick(BITCLK);
    send(8'h42, 1'b1);
    tick(BITCLK);
    check("f42_data", {24'h0, bus.data}, 32'h42);
    check("f42_rda", {31'h0, bus.rda}, 32'h1);
`ifdef SPART_RX_FERR_EN
    check("f42_ferr", {31'h0, bus.ferr}, 32'h0);
`endif

    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx.md
RX -- requirements
Module: rx

Interface
REQ-001 Parameter OSR, default 16, en ticks per bit period; legal values are powers of two from 4 to 16.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port en  input  1  baud oversample tick, one clk wide, OSR ticks per bit.
REQ-005 Port RxD  input  1  serial line, idle high, asynchronous to clk.
REQ-006 Port clr_rda  input  1  host has consumed data; clears rda.
REQ-007 Port data  output  8  last correctly framed received byte.
REQ-008 Port rda  output  1  received data available flag.
REQ-009 Port ferr  output  1  framing error flag; present only when SPART_RX_FERR_EN is defined.

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 RxD SHALL pass through a 2-flop synchronizer (rxd_s); all decisions use rxd_s only.
REQ-012 The FSM SHALL have states IDLE, START, DATA and STOP, and SHALL act only on cycles with en=1 (except reset and clr_rda).
REQ-013 IDLE: on en with rxd_s=0 and start armed -> START, tick counter loaded with OSR/2-1.
REQ-014 START: when the counter reaches 0 on en, sample rxd_s: 0 -> DATA (counter=OSR-1, bit index=0); 1 -> IDLE (glitch rejected).
REQ-015 DATA: when the counter reaches 0 on en, shift rxd_s into bit[7] of the shift register (right shift), reload the counter to OSR-1 and increment the bit index; after the 8th sample -> STOP.
REQ-016 STOP: when the counter reaches 0 on en, sample rxd_s: 1 -> data<=shift register, rda<=1, -> IDLE; 0 -> data unchanged, rda unchanged, -> IDLE with start disarmed.
REQ-017 Start SHALL be disarmed after a bad stop bit and re-armed on the first en with rxd_s=1; a held-low (break) line produces no frames.
REQ-018 rda SHALL rise on the clk edge of the stop-bit mid-sample en tick; data is valid on that same edge.
REQ-019 clr_rda=1 SHALL clear rda on the next edge; if a good stop occurs on the same edge, the set takes priority and rda stays 1.
REQ-020 Overrun: a new good frame while rda=1 SHALL overwrite data and leave rda=1; no overrun flag.
REQ-021 data SHALL hold its value between frames and SHALL never show partial bytes.

Reset
REQ-022 rst=1 SHALL force within the same clk cycle: state IDLE, synchronizer flops 1, shift register 8'h00, counters 0, start armed, data 8'h00, rda 0, ferr 0.
REQ-023 Reset mid-frame SHALL abort the frame without updating data; the next complete frame after release SHALL be received correctly.

Configuration
REQ-024 With SPART_RX_FERR_EN defined, the ferr port SHALL exist and SHALL be set on a bad stop sample, cleared by clr_rda or by the next good frame, with set winning over clr_rda.
REQ-025 Without SPART_RX_FERR_EN, the ferr port and its logic SHALL be absent, and bad frames SHALL be silently discarded per REQ-016.

Verification
REQ-026 Send 0xA5 with OSR=16 and en every 4 clk: data=0xA5 and rda=1 at the stop mid-sample; rda stays 1 until clr_rda, then 0 one edge later.
REQ-027 Pulse RxD low for 4 en ticks only: FSM returns to IDLE, rda=0 and data unchanged (0x00).
REQ-028 Send 0x3C with stop bit 0: rda=0 and data=0x00; with the macro, ferr=1; then send 0x81 correctly: data=0x81, rda=1 and ferr=0.
REQ-029 Send 0x00 then 0xFF back-to-back without clr_rda: data=0xFF and rda=1 throughout; assert clr_rda on the 0xFF stop-sample edge: rda remains 1.
REQ-030 Assert rst during data bit 4 of 0x55: data=0x00 and rda=0 immediately; release rst and send 0x96: data=0x96 and rda=1.
REQ-031 Hold RxD low for 3 frame times after a bad stop bit: no rda; raise RxD, then send 0x42: data=0x42 and rda=1.
